// File: rtl/tff_counter_pkg.sv
// tff_counter_pkg: shared constants and load clamp for the T-FF up/down counter
package tff_counter_pkg;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT = 1'b1;
  function automatic logic [31:0] clamp_load(input logic [31:0] d, input int unsigned modulus);
    return (d >= modulus) ? modulus - 1 : d;
  endfunction
endpackage

// File: rtl/tff_cell.sv
// tff_cell: 1-bit T flip-flop with synchronous active-high reset
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk)
    if (reset) q <= 1'b0;
    else q <= q ^ t;
endmodule

// File: rtl/tff_updown_counter_n.sv
// tff_updown_counter_n: modulo-N up/down counter of T cells with load, saturate and cascade outputs
module tff_updown_counter_n
  import tff_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             m,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             at_limit
);
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("tff_updown_counter_n: WIDTH out of range");
  end
  if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
    $error("tff_updown_counter_n: MODULUS out of range");
  end
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] d_cl, cnt_next, next_q, t;
  logic at_max, at_zero, oob, at_end, cnt_ok;
  always_comb begin
    d_cl = WIDTH'(clamp_load(32'(d), MODULUS));
    at_max = q == MAX;
    at_zero = q == '0;
    oob = q > MAX;
    at_end = (m == DIR_DOWN) ? at_zero : at_max;
    // a forced out-of-range value recovers to 0 regardless of direction
    cnt_next = oob ? '0
             : at_end ? ((sat == MODE_SAT) ? q : ((m == DIR_DOWN) ? MAX : '0))
             : (m == DIR_DOWN) ? q - WIDTH'(1) : q + WIDTH'(1);
    next_q = reset ? '0 : load ? d_cl : en ? cnt_next : q;
    t = q ^ next_q;
    cnt_ok = !reset && !load && en && !oob && at_end;
    tc = !reset && en && at_end;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (.clk(clk), .reset(reset), .t(t[i]), .q(q[i]));
  end
  always_ff @(posedge clk)
    if (reset) begin
      wrap <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      wrap <= cnt_ok && sat == MODE_WRAP;
      at_limit <= cnt_ok && sat == MODE_SAT;
    end
endmodule

// File: tb/tb_tff_updown_counter_n.sv
// tb_tff_updown_counter_n: directed checks of the modulo-10 counter and a two-stage cascade
module tb_tff_updown_counter_n;
  logic clk = 1'b0;
  logic reset, en, m, sat, load;
  logic [3:0] d, q;
  logic tc, wrap, at_limit;
  logic creset;
  logic [3:0] lo_q, hi_q;
  logic lo_tc, lo_wrap, lo_lim, hi_tc, hi_wrap, hi_lim;
  int n_eval = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  tff_updown_counter_n #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .reset(reset), .en(en), .m(m), .sat(sat), .load(load), .d(d),
    .q(q), .tc(tc), .wrap(wrap), .at_limit(at_limit)
  );
  tff_updown_counter_n #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .reset(creset), .en(1'b1), .m(1'b0), .sat(1'b0), .load(1'b0), .d(4'd0),
    .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .at_limit(lo_lim)
  );
  tff_updown_counter_n #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .reset(creset), .en(lo_tc), .m(1'b0), .sat(1'b0), .load(1'b0), .d(4'd0),
    .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .at_limit(hi_lim)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk3(input string tag, input logic [3:0] eq, input logic ew, input logic et);
    chk({tag, " q"}, 32'(q), 32'(eq));
    chk({tag, " wrap"}, 32'(wrap), 32'(ew));
    chk({tag, " tc"}, 32'(tc), 32'(et));
  endtask
  initial begin
    logic [3:0] up_q [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic [3:0] dn_q [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
    int hi_wraps;
    reset = 1'b1; en = 1'b1; m = 1'b1; sat = 1'b0; load = 1'b0; d = 4'd0; creset = 1'b1;
    step();
    chk("reset q", 32'(q), 0);
    chk("reset wrap", 32'(wrap), 0);
    chk("reset at_limit", 32'(at_limit), 0);
    chk("reset tc", 32'(tc), 0);
    reset = 1'b0; m = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk3("up", up_q[i], i == 9, up_q[i] == 4'd9);
    end
    load = 1'b1; d = 4'd3; en = 1'b0;
    step();
    chk3("load3", 4'd3, 1'b0, 1'b0);
    load = 1'b0; m = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk3("down", dn_q[i], i == 3, dn_q[i] == 4'd0);
    end
    sat = 1'b1; m = 1'b0; load = 1'b1; d = 4'd8; en = 1'b0;
    step();
    chk("sat load q", 32'(q), 8);
    load = 1'b0; en = 1'b1;
    step();
    chk3("sat1", 4'd9, 1'b0, 1'b1);
    chk("sat1 at_limit", 32'(at_limit), 0);
    step();
    chk3("sat2", 4'd9, 1'b0, 1'b1);
    chk("sat2 at_limit", 32'(at_limit), 1);
    step();
    chk3("sat3", 4'd9, 1'b0, 1'b1);
    chk("sat3 at_limit", 32'(at_limit), 1);
    en = 1'b0;
    step();
    chk("sat idle at_limit", 32'(at_limit), 0);
    chk("sat idle q", 32'(q), 9);
    load = 1'b1; d = 4'd15; sat = 1'b0;
    step();
    chk("clamp q", 32'(q), 9);
    d = 4'd2; en = 1'b1;
    #1;
    chk("load+tc tc", 32'(tc), 1);
    step();
    chk3("load over tc", 4'd2, 1'b0, 1'b0);
    load = 1'b0;
    repeat (4) step();
    chk("to6 q", 32'(q), 6);
    step();
    chk("dir up q", 32'(q), 7);
    m = 1'b1;
    step();
    chk("dir down q", 32'(q), 6);
    m = 1'b0;
    step();
    chk("dir back q", 32'(q), 7);
    en = 1'b0;
    step();
    chk3("hold7", 4'd7, 1'b0, 1'b0);
    en = 1'b1;
    repeat (2) step();
    chk3("to9", 4'd9, 1'b0, 1'b1);
    en = 1'b0;
    #1;
    chk("en0 tc", 32'(tc), 0);
    step();
    chk3("hold9", 4'd9, 1'b0, 1'b0);
    reset = 1'b1; load = 1'b1; d = 4'd5; en = 1'b1;
    step();
    chk3("mid reset", 4'd0, 1'b0, 1'b0);
    chk("mid reset at_limit", 32'(at_limit), 0);
    reset = 1'b0; load = 1'b0;
    creset = 1'b0;
    hi_wraps = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      hi_wraps += int'(hi_wrap);
      if (i == 57) chk("cascade 57", 32'({hi_q, lo_q}), 32'h57);
    end
    chk("cascade lo", 32'(lo_q), 0);
    chk("cascade hi", 32'(hi_q), 0);
    chk("cascade hi wrap now", 32'(hi_wrap), 1);
    chk("cascade hi wraps", 32'(hi_wraps), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end
endmodule

// File: doc/tff_updown_counter_n.md
# tff_updown_counter_n

Parametrised synchronous up/down counter built from T flip-flop cells, generalising the team's 2-bit up/down T-FF counter.
- Adds a configurable width and modulus, count enable, synchronous parallel load, and a wrap-or-saturate mode.
- Adds a combinational terminal-count output for cascading and a registered wrap pulse.
- Used as a general event/position counter and as a cascadable stage in wider counters.

## Interface
- WIDTH, 4, counter bit width; legal range 2..16
- MODULUS, 2**WIDTH, count range 0..MODULUS-1; legal range 2..2**WIDTH
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  count enable; no counting when low
- m  in  1  direction: 0 = up, 1 = down
- sat  in  1  end-of-range behaviour: 0 = wrap, 1 = saturate
- load  in  1  synchronous parallel load strobe
- d  in  WIDTH  load value
- q  out  WIDTH  counter value; reset value 0
- tc  out  1  combinational terminal count, = en & (m ? q==0 : q==MODULUS-1); 0 while reset is held
- wrap  out  1  registered one-cycle pulse marking a wrap; reset value 0
- at_limit  out  1  registered; 1 while saturated at an end value with en=1 pushing past it; reset value 0

## Operation
- Priority per edge: reset > load > en. With none active, q holds.
- reset=1: q=0, wrap=0, at_limit=0.
- load=1:
  - q=d, clamped to MODULUS-1 when d ≥ MODULUS.
  - wrap=0, at_limit=0.
  - en is ignored that cycle.
- en=1, counting up (m=0):
  - q<MODULUS-1: q+1.
  - q==MODULUS-1 with sat=0: q=0 and wrap=1 next cycle.
  - q==MODULUS-1 with sat=1: q holds and at_limit=1.
- en=1, counting down (m=1):
  - q>0: q-1.
  - q==0 with sat=0: q=MODULUS-1 and wrap=1.
  - q==0 with sat=1: q holds and at_limit=1.
- T-FF implementation:
  - Each bit i is a T cell; next state = q[i] ^ t[i].
  - The t vector is q XOR next_q, where next_q is computed above.
  - For power-of-two MODULUS and no load, this reduces to the classic ripple-free form: t[0]=1, t[i] = AND over j<i of (q[j] ^ m).
  - For load, the t vector is q ^ d_clamped.
- Out-of-range state (q ≥ MODULUS) is unreachable. If it is forced, the next enabled count goes to 0 in either direction.
- m and sat are sampled every edge; a direction change acts on the same edge it is sampled.
- en=0 with load=0: q, wrap and at_limit all hold/clear as follows: q holds, wrap=0, at_limit=0.

## Timing
- Latency: one clock from en/load/d sampling to the q update.
- tc is combinational from q, m and en, for same-cycle cascading: the next stage's en = this tc.
- wrap and at_limit are asserted in the cycle after the wrapping or saturating edge, for exactly one cycle per event. A continuous saturate keeps at_limit high.
- A reset asserted mid-count takes effect on the next edge, regardless of load/en.
- load and terminal count in the same cycle: load wins, and no wrap is produced.

## Structure
- Shared package tff_counter_pkg, containing:
  - direction constants DIR_UP=1'b0, DIR_DOWN=1'b1
  - mode constants MODE_WRAP=1'b0, MODE_SAT=1'b1
  - a function clamp_load(d, MODULUS)
- Sub-module tff_cell: 1-bit T flip-flop with synchronous active-high reset (clk, reset, t, q), instantiated WIDTH times via generate.
- The top level holds next-state/t-vector logic, tc, and the wrap/at_limit registers.
- Elaboration-time checks on the WIDTH/MODULUS legality.

## Test plan
All scenarios use WIDTH=4, MODULUS=10.
- Reset, then en=1, m=0, sat=0 for 12 clocks: q goes 1..9, 0, 1, 2; wrap is high exactly the cycle after q becomes 0; tc is high while q==9.
- load d=3, then m=1, sat=0, en=1 for 5 clocks: q=3,2,1,0,9,8; wrap pulses after 0→9; tc is high at q==0.
- sat=1, m=0, load d=8, en=1 for 4 clocks: q=8,9,9,9; at_limit=1 from the cycle after the first blocked count; tc stays 1; wrap stays 0.
- load d=15 (≥ MODULUS): q=9. Then load and en in the same cycle at q=9 with d=2: q=2, no wrap.
- Count up to q=6, flip m=1 for one edge and back: q=6,7,6,7. With en=0: q holds and tc=0.
- Cascade two instances (low stage tc → high stage en), up count 100 clocks from reset: {hi,lo} reads 0,0 after the 100th edge, with the high stage's wrap pulsing once.
